systolic_row: RTL and testbench

Parametrised weight-stationary systolic row: `COLS` processing elements share one ifmap stream that flows left to right, and each PE holds one stationary weight. Each column adds its product to a partial sum arriving from the row above and drives the result downward. It includes a weight-preload shift chain, per-column valid tracking and a control FSM that drains in-flight data before reloading weights. It is the building block that the array top stacks vertically to form an R×C systolic array.

---
 rtl/systolic_pkg.sv | 13 +
 rtl/systolic_pe.sv | 33 +++
 rtl/systolic_row.sv | 74 +++++++
 tb/tb_systolic_row.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: row FSM state type plus operand-extension and MAC helpers selected by signedness
package systolic_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
  function automatic logic [63:0] ext(input logic [63:0] v, input int unsigned w, input logic s);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return (s && v[6'(w - 1)]) ? (v | ~m) : (v & m);
  endfunction
  function automatic logic [63:0] mac(input logic [63:0] p, input logic [63:0] a, input logic [63:0] b,
                                      input int unsigned dw, input int unsigned aw, input logic s);
    return ext(p, aw, s) + ext(a, dw, s) * ext(b, dw, s);
  endfunction
endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: stationary-weight MAC cell (ports: weight shift in/out, x/valid forward, psum in/out)
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_shift,
  input  logic [DATA_W-1:0] w_in,
  output logic [DATA_W-1:0] w,
  input  logic [DATA_W-1:0] x_in,
  input  logic              v_in,
  input  logic [ACC_W-1:0]  psum_in,
  output logic [DATA_W-1:0] x_out,
  output logic              v_out,
  output logic [ACC_W-1:0]  psum_out
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w        <= '0;
      x_out    <= '0;
      v_out    <= 1'b0;
      psum_out <= '0;
    end else begin
      if (w_shift) w <= w_in;
      x_out <= x_in;
      v_out <= v_in;
      if (v_in) psum_out <= ACC_W'(mac(64'(psum_in), 64'(w), 64'(x_in), DATA_W, ACC_W, SIGNED != 0));
    end
endmodule

// File: rtl/systolic_row.sv
// systolic_row: weight-stationary row of COLS PEs with weight preload chain, valid tracking and load/drain FSM
module systolic_row
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int COLS   = 8,
  parameter int SIGNED = 0
) (
  input  logic                  iClk,
  input  logic                  iRest_n,
  input  logic                  i_load_w,
  input  logic [DATA_W-1:0]     i_w_data,
  input  logic                  i_x_valid,
  input  logic [DATA_W-1:0]     i_x_data,
  output logic                  o_x_ready,
  input  logic [COLS*ACC_W-1:0] i_psum_in,
  output logic [COLS*ACC_W-1:0] o_psum_out,
  output logic [COLS-1:0]       o_psum_valid,
  output logic [DATA_W-1:0]     o_x_out,
  output logic                  o_x_valid,
  output logic                  o_busy
);
  localparam int CW = $clog2(COLS);
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] wc [COLS+1];
  logic [DATA_W-1:0] xc [COLS+1];
  logic [COLS:0]     vc;
  logic              acc, inflight, last, unused_w;
  assign acc          = i_x_valid && o_x_ready;
  assign inflight     = |vc[COLS-1:1];
  assign last         = cnt == CW'(COLS - 1);
  assign wc[0]        = i_w_data;
  assign xc[0]        = acc ? i_x_data : '0;
  assign vc[0]        = acc;
  assign o_x_ready    = state == RUN;
  assign o_busy       = state == LOAD || state == DRAIN;
  assign o_psum_valid = vc[COLS:1];
  assign o_x_out      = xc[COLS];
  assign o_x_valid    = vc[COLS];
  assign unused_w     = ^wc[COLS];
  always_ff @(posedge iClk or negedge iRest_n)
    if (!iRest_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE:  if (i_load_w) state <= LOAD;
        LOAD: begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) state <= RUN;
        end
        RUN:   if (i_load_w) state <= (inflight || acc) ? DRAIN : LOAD;
        DRAIN: if (!inflight) state <= LOAD;
        default: state <= IDLE;
      endcase
    end
  for (genvar j = 0; j < COLS; j++) begin : g_pe
    systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_pe (
      .clk     (iClk),
      .rst_n   (iRest_n),
      .w_shift (state == LOAD),
      .w_in    (wc[j]),
      .w       (wc[j+1]),
      .x_in    (xc[j]),
      .v_in    (vc[j]),
      .psum_in (i_psum_in[j*ACC_W +: ACC_W]),
      .x_out   (xc[j+1]),
      .v_out   (vc[j+1]),
      .psum_out(o_psum_out[j*ACC_W +: ACC_W])
    );
  end
endmodule

// File: tb/tb_systolic_row.sv
// tb_systolic_row: randomized and directed checks of unsigned and signed rows against a cycle-stamped reference model
module tb_systolic_row;
  localparam int DW = 8, AW = 20, C = 4, N = 2048;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic load_w = 1'b0, x_valid = 1'b0;
  logic [DW-1:0] w_data = '0, x_data = '0;
  logic [C*AW-1:0] psum_in = '0;
  logic u_ready, u_xv, u_busy, s_ready, s_xv, s_busy;
  logic [DW-1:0] u_xo, s_xo;
  logic [C*AW-1:0] u_psum, s_psum;
  logic [C-1:0] u_pv, s_pv;
  systolic_row #(.DATA_W(DW), .ACC_W(AW), .COLS(C), .SIGNED(0)) u_dut (
    .iClk(clk), .iRest_n(rst_n), .i_load_w(load_w), .i_w_data(w_data), .i_x_valid(x_valid),
    .i_x_data(x_data), .o_x_ready(u_ready), .i_psum_in(psum_in), .o_psum_out(u_psum),
    .o_psum_valid(u_pv), .o_x_out(u_xo), .o_x_valid(u_xv), .o_busy(u_busy));
  systolic_row #(.DATA_W(DW), .ACC_W(AW), .COLS(C), .SIGNED(1)) s_dut (
    .iClk(clk), .iRest_n(rst_n), .i_load_w(load_w), .i_w_data(w_data), .i_x_valid(x_valid),
    .i_x_data(x_data), .o_x_ready(s_ready), .i_psum_in(psum_in), .o_psum_out(s_psum),
    .o_psum_valid(s_pv), .o_x_out(s_xo), .o_x_valid(s_xv), .o_busy(s_busy));
  int n_cmp = 0, n_bad = 0;
  int mode, cyc;
  logic [DW-1:0] wm [C];
  logic [DW-1:0] lq [$];
  bit acc_h [N];
  logic [DW-1:0] ax [N];
  logic [DW-1:0] aw [N][C];
  logic [AW-1:0] ph [N][C];
  logic [AW-1:0] eu [C];
  logic [AW-1:0] es [C];
  logic [C-1:0] ev;
  logic exv;
  logic [DW-1:0] exo;
  int dir [C] = '{20, 15, 10, 5};
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask
  function automatic logic [AW-1:0] mac_ref(logic [AW-1:0] p, logic [DW-1:0] w, logic [DW-1:0] x, bit s);
    int a, b;
    a = s ? int'($signed(w)) : int'(w);
    b = s ? int'($signed(x)) : int'(x);
    return AW'(int'(p) + a * b);
  endfunction
  function automatic bit acc_in(int lo, int hi);
    for (int t = lo; t <= hi; t++) if (t >= 0 && acc_h[t]) return 1'b1;
    return 1'b0;
  endfunction
  task automatic model_reset();
    mode = 0;
    cyc = 0;
    ev = '0;
    exv = 1'b0;
    exo = '0;
    lq.delete();
    for (int j = 0; j < C; j++) begin
      wm[j] = '0;
      eu[j] = '0;
      es[j] = '0;
    end
    for (int t = 0; t < N; t++) acc_h[t] = 1'b0;
  endtask
  task automatic compare();
    logic [C*AW-1:0] pu, ps;
    for (int j = 0; j < C; j++) begin
      pu[j*AW +: AW] = eu[j];
      ps[j*AW +: AW] = es[j];
    end
    check("ready_u", u_ready, mode == 2);
    check("ready_s", s_ready, mode == 2);
    check("busy_u", u_busy, mode == 1 || mode == 3);
    check("busy_s", s_busy, mode == 1 || mode == 3);
    check("pvalid_u", u_pv, ev);
    check("pvalid_s", s_pv, ev);
    check("psum_u", u_psum, pu);
    check("psum_s", s_psum, ps);
    check("xvalid_u", u_xv, exv);
    check("xout_u", u_xo, exo);
    check("xout_s", s_xo, exo);
  endtask
  task automatic step();
    bit a;
    int t;
    a = x_valid && mode == 2;
    acc_h[cyc] = a;
    ax[cyc] = x_data;
    for (int j = 0; j < C; j++) begin
      aw[cyc][j] = wm[j];
      ph[cyc][j] = psum_in[j*AW +: AW];
    end
    for (int j = 0; j < C; j++) begin
      t = cyc - j;
      ev[j] = t >= 0 && acc_h[t];
      if (ev[j]) begin
        eu[j] = mac_ref(ph[cyc][j], aw[t][j], ax[t], 1'b0);
        es[j] = mac_ref(ph[cyc][j], aw[t][j], ax[t], 1'b1);
      end
    end
    t = cyc - (C - 1);
    exv = t >= 0 && acc_h[t];
    exo = exv ? ax[t] : '0;
    case (mode)
      0: if (load_w) begin mode = 1; lq.delete(); end
      1: begin
        lq.push_back(w_data);
        if (lq.size() == C) begin
          for (int k = 0; k < C; k++) wm[C-1-k] = lq[k];
          mode = 2;
        end
      end
      2: if (load_w) begin mode = acc_in(cyc - C + 1, cyc) ? 3 : 1; lq.delete(); end
      default: if (!acc_in(cyc - C + 1, cyc - 1)) mode = 1;
    endcase
    @(posedge clk);
    #1;
    cyc++;
    compare();
  endtask
  task automatic load(input logic [DW-1:0] w0, input logic [DW-1:0] w1, input logic [DW-1:0] w2, input logic [DW-1:0] w3);
    logic [DW-1:0] ws [C];
    ws = '{w0, w1, w2, w3};
    load_w = 1'b1;
    step();
    load_w = 1'b0;
    for (int k = 0; k < C; k++) begin
      w_data = ws[k];
      step();
    end
  endtask
  initial begin
    x_valid = 1'b1;
    x_data = 8'h33;
    repeat (2) @(negedge clk);
    model_reset();
    compare();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) step();
    x_valid = 1'b0;
    load(8'd1, 8'd2, 8'd3, 8'd4);
    check("ready_after_load", u_ready, 1'b1);
    x_data = 8'd5;
    x_valid = 1'b1;
    step();
    x_valid = 1'b0;
    for (int i = 0; i < C; i++) begin
      check("pe_seq", u_psum[i*AW +: AW], dir[i]);
      step();
    end
    load(8'd0, 8'd0, 8'd0, 8'hFD);
    x_data = 8'hFE;
    x_valid = 1'b1;
    step();
    x_valid = 1'b0;
    check("sign_u", u_psum[AW-1:0], 64262);
    check("sign_s", s_psum[AW-1:0], 6);
    repeat (3) step();
    load(8'd0, 8'd0, 8'd0, 8'd1);
    psum_in[AW-1:0] = 20'hFFFFF;
    x_data = 8'd1;
    x_valid = 1'b1;
    step();
    x_valid = 1'b0;
    psum_in = '0;
    check("wrap_u", u_psum[AW-1:0], 0);
    check("wrap_s", s_psum[AW-1:0], 0);
    step();
    for (int i = 0; i < 3; i++) begin
      x_data = DW'(7 + i);
      x_valid = 1'b1;
      load_w = (i == 2);
      step();
    end
    load_w = 1'b0;
    check("reload_ready", u_ready, 1'b0);
    for (int i = 0; i < 12; i++) begin
      x_data = DW'($urandom);
      w_data = DW'($urandom);
      step();
    end
    x_valid = 1'b0;
    repeat (C) step();
    load_w = 1'b1;
    step();
    load_w = 1'b0;
    repeat (2) begin
      w_data = DW'($urandom);
      step();
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    x_valid = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 800; i++) begin
      load_w = $urandom_range(0, 19) == 0;
      x_valid = $urandom_range(0, 1) == 1;
      x_data = DW'($urandom);
      w_data = DW'($urandom);
      for (int j = 0; j < C; j++) psum_in[j*AW +: AW] = AW'($urandom);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
